// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: access modes, store queue entries
// and default sizing.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        LS_BYTE  = 3'd0,
        LS_HALF  = 3'd1,
        LS_WORD  = 3'd2,
        LS_BYTEU = 3'd3,
        LS_HALFU = 3'd4
    } ldst_mode;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        ldst_mode    mode;
    } sq_entry;

    localparam int N_RD_DEF     = 4;
    localparam int SQ_DEPTH_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_store_queue.sv
// Circular store queue with per-requester word-address match vectors and the
// youngest matching entry for each lookup.
module store_queue
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH_DEF,
    parameter int N_LK  = N_RD_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enq,
    input  sq_entry                i_ent,
    input  logic                   i_deq,
    input  logic [29:0]            i_lk_waddr [N_LK],
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output sq_entry                o_head,
    output logic [DEPTH-1:0]       o_match    [N_LK],
    output sq_entry                o_ymatch   [N_LK]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sq_entry          r_q [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_vld;

    always_ff @(posedge clk) begin
        if (i_enq) r_q[r_tail] <= i_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_enq) r_tail <= r_tail + 1'b1;
            if (i_deq) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(i_enq) - CW'(i_deq);
        end
    end

    // An entry is live when its distance from head is below count.
    for (genvar k = 0; k < DEPTH; k++) begin : g_vld
        logic [PW-1:0] w_off;
        assign w_off    = PW'(k) - r_head;
        assign w_vld[k] = {1'b0, w_off} < r_count;
    end

    for (genvar j = 0; j < N_LK; j++) begin : g_lk
        for (genvar k = 0; k < DEPTH; k++) begin : g_m
            assign o_match[j][k] = w_vld[k] &&
                (r_q[k].addr[31:2] == i_lk_waddr[j]);
        end
    end

    // Scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        for (int j = 0; j < N_LK; j++) begin
            o_ymatch[j] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (o_match[j][r_head + PW'(i)])
                    o_ymatch[j] = r_q[r_head + PW'(i)];
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_q[r_head];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: round-robin reads plus a buffered commit store queue.
// Define MEM_ARB_STORE_FWD_EN to forward exact WORD matches from the queue.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_RD         = N_RD_DEF,
    parameter int SQ_DEPTH     = SQ_DEPTH_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_RD-1:0] rd_req,
    input  logic [31:0]     rd_addr [N_RD],
    input  ldst_mode        rd_mode [N_RD],
    output logic [N_RD-1:0] rd_gnt,
    output logic [N_RD-1:0] rd_valid,
    output logic [31:0]     rd_data,
    input  logic            st_req,
    input  logic [31:0]     st_addr,
    input  logic [31:0]     st_data,
    input  ldst_mode        st_mode,
    output logic            st_full,
    output logic            mem_en,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output ldst_mode        mem_mode,
    input  logic [31:0]     mem_rdata
);
    localparam int PW = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int CW = $clog2(SQ_DEPTH) + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]       r_ptr;
    logic [AW-1:0]       r_age;
    logic [N_RD-1:0]     r_valid;

    logic [CW-1:0]       w_cnt;
    logic                w_full;
    sq_entry             w_head;
    sq_entry             w_ent;
    logic [29:0]         w_lk   [N_RD];
    logic [SQ_DEPTH-1:0] w_match  [N_RD];
    sq_entry             w_ymatch [N_RD];
    logic [N_RD-1:0]     w_elig;
    logic [N_RD-1:0]     w_fok;
    logic [PW-1:0]       w_sel;
    logic                w_any;
    int                  w_t;
    logic                w_force;
    logic                w_grant;
    logic                w_drain;
    logic                w_fwd_sel;
    logic                w_enq;

    assign w_enq = st_req && !w_full;
    assign w_ent = '{addr: st_addr, data: st_data, mode: st_mode};

    store_queue #(.DEPTH(SQ_DEPTH), .N_LK(N_RD)) u_sq (
        .clk        (clk),
        .reset      (reset),
        .i_enq      (w_enq),
        .i_ent      (w_ent),
        .i_deq      (w_drain),
        .i_lk_waddr (w_lk),
        .o_count    (w_cnt),
        .o_full     (w_full),
        .o_head     (w_head),
        .o_match    (w_match),
        .o_ymatch   (w_ymatch)
    );

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic w_sqhit;
        logic w_sthit;
        assign w_lk[i]   = rd_addr[i][31:2];
        assign w_sqhit   = |w_match[i];
        assign w_sthit   = st_req && (st_addr[31:2] == rd_addr[i][31:2]);
`ifdef MEM_ARB_STORE_FWD_EN
        assign w_fok[i]  = w_sqhit && !w_sthit &&
                           rd_mode[i] == LS_WORD &&
                           w_ymatch[i].mode == LS_WORD &&
                           w_ymatch[i].addr == rd_addr[i];
`else
        assign w_fok[i]  = 1'b0;
`endif
        assign w_elig[i] = rd_req[i] && (!(w_sqhit || w_sthit) || w_fok[i]);
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_t   = 0;
        for (int k = 0; k < N_RD; k++) begin
            w_t = int'(r_ptr) + k;
            if (w_t >= N_RD) w_t = w_t - N_RD;
            if (!w_any && w_elig[w_t]) begin
                w_any = 1'b1;
                w_sel = PW'(w_t);
            end
        end
    end

    assign w_force   = w_full || (w_cnt != '0 && r_age == AW'(STARVE_LIMIT));
    assign w_grant   = !w_force && w_any;
    assign w_drain   = w_force || (!w_any && w_cnt != '0);
    assign w_fwd_sel = w_grant && w_fok[w_sel];

    always_comb begin
        rd_gnt = '0;
        if (!reset && w_grant) rd_gnt[w_sel] = 1'b1;
    end

    assign mem_en  = !reset && (w_drain || (w_grant && !w_fwd_sel));
    assign mem_we  = !reset && w_drain;
    assign st_full = w_full;

    always_comb begin
        if (w_drain) begin
            mem_addr  = w_head.addr;
            mem_wdata = w_head.data;
            mem_mode  = w_head.mode;
        end else begin
            mem_addr  = rd_addr[w_sel];
            mem_wdata = '0;
            mem_mode  = rd_mode[w_sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_age   <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= rd_gnt;
            if (w_grant)
                r_ptr <= (w_sel == PW'(N_RD - 1)) ? '0 : w_sel + 1'b1;
            if (w_drain || w_cnt == '0)
                r_age <= '0;
            else if (r_age != AW'(STARVE_LIMIT))
                r_age <= r_age + 1'b1;
        end
    end

    assign rd_valid = r_valid;

`ifdef MEM_ARB_STORE_FWD_EN
    logic        r_fwd;
    logic [31:0] r_fwd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd      <= w_fwd_sel;
            r_fwd_data <= w_ymatch[w_sel].data;
        end
    end

    assign rd_data = r_fwd ? r_fwd_data : mem_rdata;
`else
    logic w_unused_ym;
    always_comb begin
        w_unused_ym = 1'b0;
        for (int i = 0; i < N_RD; i++) w_unused_ym = w_unused_ym ^ (^w_ymatch[i]);
    end

    assign rd_data = mem_rdata;
`endif

    // Commit must never push into a full queue; such a store is dropped.
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(st_req && st_full));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// memory operations and read responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_req;
    logic [31:0] rd_addr [4];
    ldst_mode    rd_mode [4];
    logic [3:0]  rd_gnt;
    logic [3:0]  rd_valid;
    logic [31:0] rd_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    ldst_mode    st_mode;
    logic        st_full;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    ldst_mode    mem_mode;
    logic [31:0] mem_rdata = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          en;
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  m;
        logic [3:0]  g;
    } mop_t;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
    } rsp_t;

    mop_t q_mem[$];
    rsp_t q_rsp[$];

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_mode   (rd_mode),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mode   (st_mode),
        .st_full   (st_full),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mode  (mem_mode),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is the address xor K, one cycle after the access.
    always @(posedge clk)
        mem_rdata <= (mem_en && !mem_we) ? (mem_addr ^ K) : 32'h0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_op(bit en, bit we, logic [31:0] a, logic [31:0] d,
                          ldst_mode m, logic [3:0] g);
        mop_t e;
        e.en = en; e.we = we; e.a = a; e.d = d; e.m = m; e.g = g;
        q_mem.push_back(e);
    endtask

    task automatic exp_rsp(int i, logic [31:0] d);
        rsp_t r;
        r.v = 4'(1 << i);
        r.d = d;
        q_rsp.push_back(r);
    endtask

    task automatic exp_rd(int i, logic [31:0] a, ldst_mode m);
        exp_op(1'b1, 1'b0, a, 32'h0, m, 4'(1 << i));
        exp_rsp(i, a ^ K);
    endtask

    task automatic exp_dr(logic [31:0] a, logic [31:0] d);
        exp_op(1'b1, 1'b1, a, d, LS_WORD, 4'h0);
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        st_req  = 1'b1;
        st_addr = a;
        st_data = d;
        st_mode = LS_WORD;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en || rd_gnt != 4'h0) begin
                if (q_mem.size() == 0) begin
                    chk("mem_unexpected_op", {rd_gnt, 27'h0, mem_en}, 32'h0);
                end else begin
                    mop_t e;
                    e = q_mem.pop_front();
                    chk("gnt", rd_gnt, e.g);
                    chk("mem_en", mem_en, e.en);
                    if (e.en) begin
                        chk("mem_we", mem_we, e.we);
                        chk("mem_addr", mem_addr, e.a);
                        chk("mem_mode", 32'(mem_mode), e.m);
                        if (e.we) chk("mem_wdata", mem_wdata, e.d);
                    end
                end
            end
            if (rd_valid != 4'h0) begin
                if (q_rsp.size() == 0) begin
                    chk("rd_unexpected_valid", rd_valid, 32'h0);
                end else begin
                    rsp_t r;
                    r = q_rsp.pop_front();
                    chk("rd_valid", rd_valid, r.v);
                    chk("rd_data", rd_data, r.d);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        st_req  = 1'b0;
        st_addr = '0;
        st_data = '0;
        st_mode = LS_WORD;
        for (int i = 0; i < 4; i++) begin
            rd_addr[i] = '0;
            rd_mode[i] = LS_WORD;
        end
        rd_req = 4'hF;
        tick();
        tick();
        chk("rst_gnt", rd_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_st_full", st_full, 0);
        rd_req = 4'h0;
        reset  = 1'b0;
        tick();

        // Round robin over all four requesters.
        for (int i = 0; i < 4; i++) rd_addr[i] = 32'h1000 + 32'(16 * i);
        for (int k = 0; k < 5; k++)
            exp_rd(k % 4, 32'h1000 + 32'(16 * (k % 4)), LS_WORD);
        rd_req = 4'hF;
        repeat (5) tick();
        rd_req = 4'h0;
        repeat (3) tick();

        // Idle drain of a single store.
        exp_dr(32'h100, 32'hDEAD_BEEF);
        store(32'h100, 32'hDEAD_BEEF);
        tick();
        st_req = 1'b0;
        repeat (3) tick();
        chk("drain_st_full", st_full, 0);

        // Fill the queue under a held read; fullness forces a drain.
        rd_addr[2] = 32'h2000;
        for (int k = 0; k < 4; k++) exp_rd(2, 32'h2000, LS_WORD);
        exp_dr(32'h400, 32'h1111_0000);
        exp_rd(2, 32'h2000, LS_WORD);
        for (int k = 1; k < 4; k++)
            exp_dr(32'h400 + 32'(4 * k), 32'h1111_0000 + 32'(k));
        rd_req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            store(32'h400 + 32'(4 * k), 32'h1111_0000 + 32'(k));
            tick();
        end
        st_req = 1'b0;
        chk("full_set", st_full, 1);
        tick();
        chk("full_clear", st_full, 0);
        tick();
        rd_req = 4'h0;
        repeat (5) tick();

        // Starvation: a queued store waits exactly eight denied cycles.
        rd_addr[0] = 32'h3000;
        rd_addr[1] = 32'h3004;
        exp_rd(0, 32'h3000, LS_WORD);
        for (int k = 1; k <= 8; k++)
            exp_rd(k % 2, (k % 2) ? 32'h3004 : 32'h3000, LS_WORD);
        exp_dr(32'h500, 32'hCAFE_F00D);
        exp_rd(1, 32'h3004, LS_WORD);
        rd_req = 4'b0011;
        store(32'h500, 32'hCAFE_F00D);
        tick();
        st_req = 1'b0;
        repeat (10) tick();
        rd_req = 4'h0;
        repeat (3) tick();

        // Hazard: read to the same word waits until the store drains.
        rd_addr[3] = 32'h202;
        rd_mode[3] = LS_HALF;
        exp_dr(32'h200, 32'h0BAD_F00D);
        exp_rd(3, 32'h202, LS_HALF);
        rd_req = 4'b1000;
        store(32'h200, 32'h0BAD_F00D);
        tick();
        st_req = 1'b0;
        tick();
        tick();
        rd_req = 4'h0;
        repeat (3) tick();

        // Exact WORD read of a queued WORD store.
        store(32'h300, 32'h1234_5678);
        tick();
        st_req     = 1'b0;
        rd_addr[0] = 32'h300;
        rd_mode[0] = LS_WORD;
`ifdef MEM_ARB_STORE_FWD_EN
        exp_op(1'b0, 1'b0, 32'h0, 32'h0, LS_WORD, 4'b0001);
        exp_rsp(0, 32'h1234_5678);
        exp_dr(32'h300, 32'h1234_5678);
        rd_req = 4'b0001;
        tick();
        rd_req = 4'h0;
`else
        exp_dr(32'h300, 32'h1234_5678);
        exp_rd(0, 32'h300, LS_WORD);
        rd_req = 4'b0001;
        tick();
        tick();
        rd_req = 4'h0;
`endif
        repeat (3) tick();

        // Reset mid-operation discards queued stores and pending rd_valid.
        rd_addr[1] = 32'h3100;
        exp_rd(1, 32'h3100, LS_WORD);
        exp_op(1'b1, 1'b0, 32'h3100, 32'h0, LS_WORD, 4'b0010);
        rd_req = 4'b0010;
        store(32'h600, 32'h6666_0000);
        tick();
        store(32'h604, 32'h6666_0004);
        tick();
        reset  = 1'b1;
        rd_req = 4'h0;
        st_req = 1'b0;
        #1;
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_st_full", st_full, 0);
        chk("midrst_mem_en", mem_en, 0);
        tick();
        reset = 1'b0;
        repeat (6) tick();

        chk("mem_queue_drained", q_mem.size(), 0);
        chk("rsp_queue_drained", q_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
